// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access. Data has priority,
// bounded by a streak limiter so a pending fetch still progresses; hung accesses time out.
module mem_arbiter #(
   parameter int WORD_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic              ramready,
   output logic              ram_err
);
   localparam int SW = $clog2(MAX_DSTREAK + 1);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [WORD_W-1:0] ABORT_WORD = WORD_W'(32'hBAD1BAD1);

   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] dstreak;
   logic [CW-1:0] busy_cnt;
   logic          dreq, grant_d, grant_i, expire;

   assign dreq    = dREN | dWEN;
   assign grant_d = dreq & ~(iREN & (dstreak == SW'(MAX_DSTREAK)));
   assign grant_i = ~grant_d & iREN;
   // last permitted BUSY cycle passing without ramready
   assign expire  = ~ramready & (busy_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d)      state_nxt = BUSY_D;
            else if (grant_i) state_nxt = BUSY_I;
         end
         BUSY_I:  if (ramready | expire) state_nxt = RESP_I;
         BUSY_D:  if (ramready | expire) state_nxt = RESP_D;
         RESP_I:  state_nxt = IDLE;
         RESP_D:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      iwait = iREN & (state != RESP_I);
      dwait = dreq & (state != RESP_D);
   end

   // Strobes are registered so they stay flat for the whole BUSY interval;
   // ramREN doubles as the latched read/write op.
   always_ff @(posedge CLK) begin
      if (RST) begin
         iload    <= '0;
         dload    <= '0;
         ramREN   <= 1'b0;
         ramWEN   <= 1'b0;
         ramaddr  <= '0;
         ramstore <= '0;
         dstreak  <= '0;
         busy_cnt <= '0;
         ram_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  ramaddr  <= daddr;
                  ramstore <= dstore;
                  ramWEN   <= dWEN;
                  ramREN   <= ~dWEN;
                  busy_cnt <= '0;
                  if (!iREN)                               dstreak <= '0;
                  else if (dstreak != SW'(MAX_DSTREAK))    dstreak <= dstreak + SW'(1);
               end else if (grant_i) begin
                  ramaddr  <= iaddr;
                  ramREN   <= 1'b1;
                  ramWEN   <= 1'b0;
                  busy_cnt <= '0;
                  dstreak  <= '0;
               end
            end
            BUSY_I: begin
               if (ramready) begin
                  iload  <= ramload;
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
               end else if (expire) begin
                  iload   <= ABORT_WORD;
                  ram_err <= 1'b1;
                  ramREN  <= 1'b0;
                  ramWEN  <= 1'b0;
               end else begin
                  busy_cnt <= busy_cnt + CW'(1);
               end
            end
            BUSY_D: begin
               if (ramready) begin
                  if (ramREN) dload <= ramload;
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
               end else if (expire) begin
                  dload   <= ABORT_WORD;
                  ram_err <= 1'b1;
                  ramREN  <= 1'b0;
                  ramWEN  <= 1'b0;
               end else begin
                  busy_cnt <= busy_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vector table, directed corner sequences and a
// randomized run against a memory-semantics model.
module tb_mem_arbiter;
   localparam int WW = 32, AW = 32, MDS = 4, TO = 64;

   logic          CLK = 1'b0, RST = 1'b1;
   logic          iREN = 0, dREN = 0, dWEN = 0, ramready = 0;
   logic [AW-1:0] iaddr = '0, daddr = '0, ramaddr;
   logic [WW-1:0] dstore = '0, ramload = '0, iload, dload, ramstore;
   logic          iwait, dwait, ramREN, ramWEN, ram_err;

   mem_arbiter #(.WORD_W(WW), .ADDR_W(AW), .MAX_DSTREAK(MDS), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready), .ram_err(ram_err));

   always #5 CLK = ~CLK;

   int tests = 0, fails = 0;
   bit ram_auto = 0;
   int ram_lat_max = 0, lat_cnt = 0;
   logic [31:0] ram [logic [31:0]];
   logic [31:0] mdl [logic [31:0]];

   typedef struct {
      logic        rst, iren, dren, dwen, rdy;
      logic [31:0] ia, da, ds, rl;
      logic        e_iw, e_dw, e_rr, e_rw, e_err;
      logic [31:0] e_il, e_dl;
      logic        c_ra, c_rs;
      logic [31:0] e_ra, e_rs;
   } vec_t;

   function automatic vec_t mk(logic rst, logic iren, logic [31:0] ia, logic dren, logic dwen,
                               logic [31:0] da, logic [31:0] ds, logic rdy, logic [31:0] rl,
                               logic iw, logic dw, logic rr, logic rw, logic er,
                               logic [31:0] il, logic [31:0] dl,
                               logic cra, logic [31:0] ra, logic crs, logic [31:0] rs);
      vec_t v;
      v.rst = rst; v.iren = iren; v.ia = ia; v.dren = dren; v.dwen = dwen; v.da = da; v.ds = ds;
      v.rdy = rdy; v.rl = rl; v.e_iw = iw; v.e_dw = dw; v.e_rr = rr; v.e_rw = rw; v.e_err = er;
      v.e_il = il; v.e_dl = dl; v.c_ra = cra; v.e_ra = ra; v.c_rs = crs; v.e_rs = rs;
      return v;
   endfunction

   function automatic logic [31:0] ifunc(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock; the bench RAM then answers strobes after a random latency.
   task automatic cyc();
      @(posedge CLK); #1;
      if (ram_auto) begin
         if (ramREN | ramWEN) begin
            if (lat_cnt == 0) begin
               ramready = 1'b1;
               if (ramWEN) ram[ramaddr] = ramstore;
               ramload = ram.exists(ramaddr) ? ram[ramaddr] : ifunc(ramaddr);
            end else begin
               ramready = 1'b0;
               lat_cnt--;
            end
         end else begin
            ramready = 1'b0;
            lat_cnt = $urandom_range(ram_lat_max, 0);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      RST = 1; iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
      cyc(); cyc();
      RST = 0;
   endtask

   task automatic wait_strobe(input string nm);
      for (int c = 0; c < 10 && !(ramREN | ramWEN); c++) cyc();
      chk(nm, ramREN | ramWEN, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];
      string seq;
      logic prev;
      int n;
      bit ia, da, dw;
      logic [31:0] i_a, d_a, d_s;
      int i_age, d_age, dcount;

      // rst iren ia dren dwen da ds rdy rl | iw dw rr rw err il dl | c_ra ra c_rs rs
      tbl.push_back(mk(1,1,'h40,0,0,0,0,0,0,                1,0,0,0,0,0,0,                 1,0,1,0));
      tbl.push_back(mk(0,1,'h40,0,0,0,0,0,0,                1,0,0,0,0,0,0,                 1,0,1,0));
      tbl.push_back(mk(0,1,'h40,0,0,0,0,1,'h8C220004,       1,0,1,0,0,0,0,                 1,'h40,0,0));
      tbl.push_back(mk(0,1,'h40,0,0,0,0,0,0,                0,0,0,0,0,'h8C220004,0,        0,0,0,0));
      tbl.push_back(mk(0,0,'h40,0,0,0,0,0,0,                0,0,0,0,0,'h8C220004,0,        0,0,0,0));
      tbl.push_back(mk(0,1,'h44,0,1,'h100,'hDEADBEEF,0,0,   1,1,0,0,0,'h8C220004,0,        0,0,0,0));
      tbl.push_back(mk(0,1,'h44,0,1,'h100,'hDEADBEEF,0,0,   1,1,0,1,0,'h8C220004,0,        1,'h100,1,'hDEADBEEF));
      tbl.push_back(mk(0,1,'h44,0,1,'h100,'hDEADBEEF,1,'h12345678, 1,1,0,1,0,'h8C220004,0, 1,'h100,1,'hDEADBEEF));
      tbl.push_back(mk(0,1,'h44,0,1,'h100,'hDEADBEEF,0,0,   1,0,0,0,0,'h8C220004,0,        0,0,0,0));
      tbl.push_back(mk(0,1,'h44,0,0,0,0,0,0,                1,0,0,0,0,'h8C220004,0,        0,0,0,0));
      tbl.push_back(mk(0,1,'h44,0,0,0,0,1,'hCAFEF00D,       1,0,1,0,0,'h8C220004,0,        1,'h44,0,0));
      tbl.push_back(mk(0,1,'h44,0,0,0,0,0,0,                0,0,0,0,0,'hCAFEF00D,0,        0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                   0,0,0,0,0,'hCAFEF00D,0,        0,0,0,0));
      tbl.push_back(mk(0,0,0,1,0,'h200,0,0,0,               0,1,0,0,0,'hCAFEF00D,0,        0,0,0,0));
      tbl.push_back(mk(0,0,0,1,0,'h200,0,1,'h11223344,      0,1,1,0,0,'hCAFEF00D,0,        1,'h200,0,0));
      tbl.push_back(mk(0,0,0,1,0,'h200,0,0,0,               0,0,0,0,0,'hCAFEF00D,'h11223344, 0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1,'hFFFFFFFF,          0,0,0,0,0,'hCAFEF00D,'h11223344, 0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1,'hFFFFFFFF,          0,0,0,0,0,'hCAFEF00D,'h11223344, 0,0,0,0));

      do_reset();
      foreach (tbl[k]) begin
         cyc();
         RST = tbl[k].rst; iREN = tbl[k].iren; iaddr = tbl[k].ia; dREN = tbl[k].dren;
         dWEN = tbl[k].dwen; daddr = tbl[k].da; dstore = tbl[k].ds;
         ramready = tbl[k].rdy; ramload = tbl[k].rl;
         #1;
         chk($sformatf("v%0d_iwait", k), iwait, tbl[k].e_iw);
         chk($sformatf("v%0d_dwait", k), dwait, tbl[k].e_dw);
         chk($sformatf("v%0d_ramREN", k), ramREN, tbl[k].e_rr);
         chk($sformatf("v%0d_ramWEN", k), ramWEN, tbl[k].e_rw);
         chk($sformatf("v%0d_ram_err", k), ram_err, tbl[k].e_err);
         chk($sformatf("v%0d_iload", k), iload, tbl[k].e_il);
         chk($sformatf("v%0d_dload", k), dload, tbl[k].e_dl);
         if (tbl[k].c_ra) chk($sformatf("v%0d_ramaddr", k), ramaddr, tbl[k].e_ra);
         if (tbl[k].c_rs) chk($sformatf("v%0d_ramstore", k), ramstore, tbl[k].e_rs);
      end

      // Both sides held: data wins MAX_DSTREAK times, then one fetch, repeating.
      do_reset();
      ram_auto = 1; ram_lat_max = 0;
      iREN = 1; iaddr = 'h80; dREN = 1; daddr = 'h300;
      seq = ""; prev = 0;
      for (int c = 0; c < 80 && seq.len() < 10; c++) begin
         cyc();
         if (ramREN && !prev) seq = {seq, (ramaddr == 32'h300) ? "D" : "I"};
         prev = ramREN;
      end
      tests++;
      if (seq != "DDDDIDDDDI") begin
         fails++;
         $display("FAIL streak_order: got %s expected DDDDIDDDDI", seq);
      end
      ram_auto = 0;

      // Hung RAM on a data read.
      do_reset();
      ramready = 0; dREN = 1; daddr = 'h400;
      wait_strobe("to_grant");
      n = 0;
      while (ramREN && n < 200) begin n++; cyc(); end
      chk("to_busy_len", n, TO);
      chk("to_dwait_resp", dwait, 1'b0);
      chk("to_dload", dload, 32'hBAD1BAD1);
      chk("to_err_set", ram_err, 1'b1);
      cyc();
      chk("to_dwait_after", dwait, 1'b1);
      dREN = 0;
      for (int c = 0; c < 5; c++) cyc();
      chk("to_err_sticky", ram_err, 1'b1);
      do_reset();
      #1;
      chk("to_err_cleared", ram_err, 1'b0);

      // Reset in the middle of a slow fetch.
      iREN = 1; iaddr = 'h500;
      wait_strobe("rst_grant");
      cyc(); cyc();
      RST = 1;
      cyc();
      chk("rst_ramREN", ramREN, 1'b0);
      chk("rst_iload", iload, 32'h0);
      chk("rst_iwait_held", iwait, 1'b1);
      RST = 0; iREN = 0;
      cyc(); cyc();
      ramready = 1; ramload = 'h77777777;
      #1;
      chk("rst_late_iwait", iwait, 1'b0);
      cyc();
      ramready = 0;
      chk("rst_late_ramREN", ramREN, 1'b0);
      chk("rst_late_iload", iload, 32'h0);

      // Fetch request withdrawn while BUSY_I.
      iREN = 1; iaddr = 'h600;
      wait_strobe("drop_grant");
      iREN = 0;
      #1;
      chk("drop_iwait0", iwait, 1'b0);
      cyc();
      chk("drop_ramREN", ramREN, 1'b1);
      chk("drop_ramaddr", ramaddr, 32'h600);
      ramready = 1; ramload = 'hA5A5A5A5;
      cyc();
      ramready = 0;
      chk("drop_iload", iload, 32'hA5A5A5A5);
      chk("drop_iwait1", iwait, 1'b0);
      chk("drop_strobe_off", ramREN, 1'b0);
      cyc(); cyc();
      chk("drop_idle", ramREN | ramWEN, 1'b0);

      // Randomized traffic; fetch region is read-only, data region is read/write.
      do_reset();
      ram.delete(); mdl.delete();
      ram_auto = 1; ram_lat_max = 3; lat_cnt = 0;
      ia = 0; da = 0; dw = 0; i_a = 0; d_a = 0; d_s = 0;
      i_age = 0; d_age = 0; dcount = 0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         if (ia) begin
            i_age++;
            if (!iwait) begin
               chk("rnd_iload", iload, ifunc(i_a));
               chk("rnd_streak_bound", dcount <= MDS + 1, 1'b1);
               ia = 0;
            end else if (i_age > 200) begin
               chk("rnd_fetch_stuck", i_age, 0);
               break;
            end
         end
         if (da) begin
            d_age++;
            if (!dwait) begin
               if (dw) mdl[d_a] = d_s;
               else    chk("rnd_dload", dload, mdl.exists(d_a) ? mdl[d_a] : ifunc(d_a));
               if (ia) dcount++;
               da = 0;
            end else if (d_age > 200) begin
               chk("rnd_data_stuck", d_age, 0);
               break;
            end
         end
         if (!ia && $urandom_range(3, 0) == 0) begin
            ia = 1; i_a = 32'h1000 + ($urandom_range(63, 0) << 2); i_age = 0; dcount = 0;
         end
         if (!da && $urandom_range(2, 0) == 0) begin
            da = 1; dw = 1'($urandom_range(1, 0));
            d_a = 32'h2000 + ($urandom_range(7, 0) << 2); d_s = $urandom; d_age = 0;
         end
         iREN = ia; iaddr = ia ? i_a : $urandom;
         dWEN = da & dw;
         dREN = da & (~dw | 1'($urandom_range(1, 0)));
         daddr = d_a; dstore = d_s;
      end
      chk("rnd_no_err", ram_err, 1'b0);
      ram_auto = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
